vc_ram_cmd_sequencer: RTL

Per-hash front end of the data-RAM command path. Round-robin arbitrates the four directional request streams (west, east, south, north) of arb_out_req_t commands. Expands each granted command into read_ram_cmd_t beats: one beat for read/write, DS_N beats for linefill/evict. It sits between the direction arbiters and the SRAM instance command port, and holds the RAM until the last beat of a multi-beat transfer is accepted.

---
 rtl/vc_ram_cmd_sequencer_if.sv | 71 +++++++
 rtl/vc_ram_cmd_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vc_ram_cmd_sequencer_if.sv
// Payload types and the request/command bundle shared by the data-RAM
// command sequencer and its neighbours (direction arbiters, SRAM port).

package vc_ram_cmd_sequencer_pkg;

    localparam int unsigned DS_N      = 4;
    localparam int unsigned REQ_NUM_W = $clog2(DS_N);
    localparam int unsigned OPC_W     = 4;

    // Arbitrated request command, 110 bits.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic             last;
        logic [1:0]       direction_id;
        logic [7:0]       rob_entry_id;
        logic [9:0]       index;
        logic [28:0]      tag;
        logic [7:0]       byte_en;
        logic [47:0]      attr;
    } arb_out_req_t;

    // One beat toward the RAM, 113 bits.
    typedef struct packed {
        arb_out_req_t           req_cmd_pld;
        logic                   last;
        logic [REQ_NUM_W-1:0]   req_num;
    } read_ram_cmd_t;

endpackage

interface vc_ram_cmd_sequencer_if #(
    parameter int unsigned REQ_PORTS = 4
);
    import vc_ram_cmd_sequencer_pkg::*;

    localparam int unsigned SRC_W = (REQ_PORTS > 1) ? $clog2(REQ_PORTS) : 1;

    logic [REQ_PORTS-1:0]         req_vld;
    arb_out_req_t [REQ_PORTS-1:0] req_pld;
    logic [REQ_PORTS-1:0]         req_rdy;
    logic                         cmd_vld;
    read_ram_cmd_t                cmd_pld;
    logic                         cmd_rdy;
    logic [SRC_W-1:0]             cmd_src;
    logic                         busy;

    // Sequencer side: consumes requests, issues beats.
    modport master (
        input  req_vld,
        input  req_pld,
        input  cmd_rdy,
        output req_rdy,
        output cmd_vld,
        output cmd_pld,
        output cmd_src,
        output busy
    );

    // Environment side: direction arbiters plus RAM command port.
    modport slave (
        output req_vld,
        output req_pld,
        output cmd_rdy,
        input  req_rdy,
        input  cmd_vld,
        input  cmd_pld,
        input  cmd_src,
        input  busy
    );

endinterface

// File: rtl/vc_ram_cmd_sequencer.sv
// Round-robin arbiter over the four direction request streams that expands
// each granted command into one (read/write) or BEATS (linefill/evict) RAM
// beats, holding the RAM for the whole burst.

module vc_ram_cmd_sequencer
    import vc_ram_cmd_sequencer_pkg::*;
#(
    parameter int unsigned REQ_PORTS    = 4,
    parameter int unsigned BEATS        = DS_N,
    parameter int unsigned OPC_LINEFILL = 2,
    parameter int unsigned OPC_EVICT    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vc_ram_cmd_sequencer_if.master bus_if
);

    localparam int unsigned PTR_W  = (REQ_PORTS > 1) ? $clog2(REQ_PORTS) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    arb_out_req_t         hold_q, hold_d;
    logic [PTR_W-1:0]     src_q, src_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]    last_idx_q, last_idx_d;

    logic                 win_vld_c;
    logic [PTR_W-1:0]     win_idx_c;
    logic [OPC_W-1:0]     win_opc_c;
    logic                 multi_c;
    logic                 beat_last_c;
    logic                 beat_acc_c;
    logic                 grant_ok_c;
    logic                 xfer_c;

    // Round-robin search starting at rr_ptr_q, first valid port wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        cand      = '0;
        for (int unsigned k = 0; k < REQ_PORTS; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % REQ_PORTS);
            if (!win_vld_c && bus_if.req_vld[cand]) begin
                win_vld_c = 1'b1;
                win_idx_c = cand;
            end
        end
    end

    // Handshake qualifiers: a new grant is taken only when idle or while the
    // final beat of the current command is being accepted.
    assign win_opc_c   = bus_if.req_pld[win_idx_c].opcode;
    assign multi_c     = (win_opc_c == OPC_W'(OPC_LINEFILL)) ||
                         (win_opc_c == OPC_W'(OPC_EVICT));
    assign beat_last_c = (beat_cnt_q == last_idx_q);
    assign beat_acc_c  = (state_q == ST_ISSUE) && bus_if.cmd_rdy;
    assign grant_ok_c  = (state_q == ST_IDLE) || (beat_acc_c && beat_last_c);
    assign xfer_c      = grant_ok_c && win_vld_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: back-to-back grants on the last beat keep us in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat_acc_c && beat_last_c) begin
                    state_d = xfer_c ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on transfer, advance beat on accept.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        src_d      = src_q;
        beat_cnt_d = beat_cnt_q;
        last_idx_d = last_idx_q;
        if (xfer_c) begin
            rr_ptr_d   = (win_idx_c == PTR_W'(REQ_PORTS - 1)) ? '0
                                                              : win_idx_c + PTR_W'(1);
            hold_d     = bus_if.req_pld[win_idx_c];
            src_d      = win_idx_c;
            beat_cnt_d = '0;
            last_idx_d = multi_c ? BEAT_W'(BEATS - 1) : '0;
        end else if (beat_acc_c && !beat_last_c) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
    end

    // Datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            hold_q     <= '0;
            src_q      <= '0;
            beat_cnt_q <= '0;
            last_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
            last_idx_q <= last_idx_d;
        end
    end

    // Outputs: beat fields come straight from registers; zero when idle.
    always_comb begin
        read_ram_cmd_t beat;
        beat           = '0;
        bus_if.cmd_vld = 1'b0;
        bus_if.busy    = 1'b0;
        bus_if.cmd_src = src_q;
        bus_if.req_rdy = xfer_c ? (REQ_PORTS'(1) << win_idx_c) : '0;
        if (state_q == ST_ISSUE) begin
            bus_if.cmd_vld        = 1'b1;
            bus_if.busy           = 1'b1;
            beat.req_cmd_pld      = hold_q;
            beat.req_cmd_pld.last = beat_last_c;
            beat.last             = beat_last_c;
            beat.req_num          = REQ_NUM_W'(beat_cnt_q);
        end
        bus_if.cmd_pld = beat;
    end

    // At most one port is accepted per cycle.
    a_req_rdy_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(bus_if.req_rdy));

    // A stalled beat is held unchanged and no new request is taken.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus_if.cmd_vld && !bus_if.cmd_rdy) |=>
            (bus_if.cmd_vld && $stable(bus_if.cmd_pld) && $stable(bus_if.cmd_src)));

endmodule
